frame_deserializer: RTL and testbench
=====================================

Name: frame_deserializer

Overview:
- Consumes the serial bit stream (`received_bit`) and the `video_data_ready` / `audio_data_ready` qualifiers produced by the SPI data FSM.
- Packs bits MSB-first into words and issues write strobes, addresses and data to a double-banked video frame RAM and an audio sample RAM.
- Flips the video bank and pulses `frame_done` when a complete video+audio frame has landed, so the display side can swap banks.
- Flags protocol errors (partial words, short frames, both qualifiers active together).

Parameters:
- VID_WORD_W, 8, bits per video RAM word.
- VID_DEPTH, 9600, video words per frame (address range 0..VID_DEPTH-1).
- AUD_WORD_W, 16, bits per audio sample word.
- AUD_DEPTH, 1024, audio words per frame.

Ports:
- CLK_40  in  1  system clock, 40 MHz.
- reset  in  1  asynchronous, active-low reset.
- data_clk_rising_edge  in  1  one-cycle bit strobe; a bit is valid only in strobe cycles.
- received_bit  in  1  serial data bit.
- video_data_ready  in  1  current strobed bit belongs to video.
- audio_data_ready  in  1  current strobed bit belongs to audio.
- vid_wr_en  out  1  video RAM write strobe, one cycle.
- vid_wr_bank  out  1  bank being written; the display reads ~vid_wr_bank.
- vid_wr_addr  out  $clog2(VID_DEPTH)  video word address.
- vid_wr_data  out  VID_WORD_W  video word.
- aud_wr_en  out  1  audio RAM write strobe, one cycle.
- aud_wr_addr  out  $clog2(AUD_DEPTH)  audio word address.
- aud_wr_data  out  AUD_WORD_W  audio word.
- frame_done  out  1  one-cycle pulse at the end of a frame.
- err_partial  out  1  sticky: a word was abandoned mid-assembly.
- err_short  out  1  sticky: audio started before video reached VID_DEPTH words.
- err_both  out  1  sticky: both ready signals high in one strobe cycle.

Behaviour:
- Reset (reset=0, asynchronous): all outputs 0, state=IDLE, shift registers, bit counters and addresses 0. Reset asserted mid-frame discards the frame in progress; vid_wr_bank returns to 0.
- Bit accept: a bit is accepted on the CLK_40 edge where data_clk_rising_edge=1 and the matching ready=1.
  - Shift is left-shift, new bit into the LSB, so the first bit ends up as the MSB.
  - Bit counter width is $clog2(word_w+1).
- Word complete: on the edge that accepts bit number word_w, the write outputs are registered in the same edge.
  - *_wr_en=1 for exactly one cycle. Latency is 1 CLK_40 cycle from the last-bit edge to wr_en visible.
  - *_wr_data holds the full word and *_wr_addr holds the current word index.
  - The address increments on the following edge; the bit counter clears.
- Data outputs hold their last value while wr_en=0.
- Both ready signals high in a strobe cycle: video has priority, the audio bit is dropped, and err_both is set.
- State machine (advances only on strobe cycles):
  - IDLE -> VIDEO on video_data_ready=1. IDLE -> AUDIO on audio_data_ready=1, which also sets err_short.
  - VIDEO: accepts video bits. After the write at vid_wr_addr=VID_DEPTH-1, the address wraps to 0 and the internal flag vid_full is set.
    - Further video bits while vid_full=1 are ignored; no wrap overwrite.
    - audio_data_ready=1 moves to AUDIO.
    - If vid_full=0 at that point, err_short is set.
    - A nonzero video bit count at that point sets err_partial and the partial word is discarded.
  - AUDIO: accepts audio bits.
    - After the write at aud_wr_addr=AUD_DEPTH-1, the next edge goes to IDLE and pulses frame_done=1 for one cycle.
    - vid_wr_bank toggles on that same edge, but only if vid_full=1; a short frame does not swap banks.
    - Both addresses, both bit counters and vid_full clear on that same edge.
  - Strobe with both ready=0 while in VIDEO or AUDIO with a nonzero bit count: err_partial is set, the partial word is discarded, and the state is held.
- Error flags are sticky until reset.

Test Plan:
- VID_WORD_W=8, VID_DEPTH=4, AUD_WORD_W=16, AUD_DEPTH=2. Send 32 video bits forming bytes 0xA5,0x3C,0xFF,0x01, then 32 audio bits forming 0x1234,0xBEEF.
  - Expect 4 vid_wr_en pulses at addr 0..3 with those bytes, then 2 aud_wr_en pulses at addr 0..1 with 0x1234,0xBEEF.
  - Expect frame_done pulsed once, vid_wr_bank 0->1, all err flags 0.
- Same frame twice back-to-back: expect vid_wr_bank 0->1->0, two frame_done pulses, addresses restarting at 0 for frame 2.
- Strobe spacing: strobes 4 cycles apart with received_bit toggling every cycle. Expect only the strobe-cycle values captured, and wr_en exactly 1 cycle after the 8th accepted bit.
- Short frame: send 16 video bits then audio. Expect err_short=1, 2 video writes, and no bank toggle after the audio completes.
- Partial word: 5 video bits, then a strobe with both ready=0, then 8 more video bits. Expect err_partial=1 and a single write of the last 8 bits at addr 0.
- Reset pulse low after 20 video bits: all outputs 0 immediately (asynchronous), then a normal full frame writes from addr 0 with vid_wr_bank starting at 0.

Source files
------------

// File: rtl/frame_deserializer.sv
// Deserializes the strobed SPI bit stream into video/audio RAM words and
// swaps the double-banked video frame once a complete video+audio frame lands.
module frame_deserializer #(
  parameter int VID_WORD_W = 8,
  parameter int VID_DEPTH  = 9600,
  parameter int AUD_WORD_W = 16,
  parameter int AUD_DEPTH  = 1024
) (
  input  logic                         CLK_40,
  input  logic                         reset,
  input  logic                         data_clk_rising_edge,
  input  logic                         received_bit,
  input  logic                         video_data_ready,
  input  logic                         audio_data_ready,
  output logic                         vid_wr_en,
  output logic                         vid_wr_bank,
  output logic [$clog2(VID_DEPTH)-1:0] vid_wr_addr,
  output logic [VID_WORD_W-1:0]        vid_wr_data,
  output logic                         aud_wr_en,
  output logic [$clog2(AUD_DEPTH)-1:0] aud_wr_addr,
  output logic [AUD_WORD_W-1:0]        aud_wr_data,
  output logic                         frame_done,
  output logic                         err_partial,
  output logic                         err_short,
  output logic                         err_both
);

  localparam int VA_W = $clog2(VID_DEPTH);
  localparam int AA_W = $clog2(AUD_DEPTH);
  localparam int VC_W = $clog2(VID_WORD_W + 1);
  localparam int AC_W = $clog2(AUD_WORD_W + 1);
  localparam logic [VA_W-1:0] VID_LAST  = VA_W'(VID_DEPTH - 1);
  localparam logic [AA_W-1:0] AUD_LAST  = AA_W'(AUD_DEPTH - 1);
  localparam logic [VC_W-1:0] VID_FINAL = VC_W'(VID_WORD_W - 1);
  localparam logic [AC_W-1:0] AUD_FINAL = AC_W'(AUD_WORD_W - 1);

  // DONE is the single cycle after the last audio write that closes the frame
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    VIDEO = 2'd1,
    AUDIO = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                state_r;
  logic [VID_WORD_W-2:0] vid_sh_r;
  logic [VC_W-1:0]       vid_cnt_r;
  logic [VA_W-1:0]       vid_idx_r;
  logic                  vid_full_r;
  logic [AUD_WORD_W-2:0] aud_sh_r;
  logic [AC_W-1:0]       aud_cnt_r;
  logic [AA_W-1:0]       aud_idx_r;

  logic                  vid_strobe_s;
  logic                  aud_strobe_s;
  logic                  nil_strobe_s;
  logic                  vid_take_s;
  logic                  aud_take_s;
  logic                  vid_word_s;
  logic                  aud_word_s;
  logic                  vid_drop_s;
  logic                  aud_drop_s;
  logic [VID_WORD_W-1:0] vid_next_s;
  logic [AUD_WORD_W-1:0] aud_next_s;

  // Strobe qualification: video wins when both readies are high
  always_comb begin
    vid_strobe_s = data_clk_rising_edge && video_data_ready;
    aud_strobe_s = data_clk_rising_edge && audio_data_ready && !video_data_ready;
    nil_strobe_s = data_clk_rising_edge && !video_data_ready && !audio_data_ready;
    vid_take_s   = vid_strobe_s && ((state_r == IDLE) || (state_r == VIDEO)) && !vid_full_r;
    aud_take_s   = aud_strobe_s && (state_r != DONE);
    vid_word_s   = vid_take_s && (vid_cnt_r == VID_FINAL);
    aud_word_s   = aud_take_s && (aud_cnt_r == AUD_FINAL);
    vid_drop_s   = (state_r == VIDEO) && (aud_strobe_s || nil_strobe_s) && (vid_cnt_r != VC_W'(0));
    aud_drop_s   = (state_r == AUDIO) && nil_strobe_s && (aud_cnt_r != AC_W'(0));
    vid_next_s   = {vid_sh_r, received_bit};
    aud_next_s   = {aud_sh_r, received_bit};
  end

  // Word assembly, RAM write outputs, error flags and frame sequencing
  always_ff @(posedge CLK_40 or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      vid_sh_r    <= '0;
      vid_cnt_r   <= VC_W'(0);
      vid_idx_r   <= VA_W'(0);
      vid_full_r  <= 1'b0;
      aud_sh_r    <= '0;
      aud_cnt_r   <= AC_W'(0);
      aud_idx_r   <= AA_W'(0);
      vid_wr_en   <= 1'b0;
      vid_wr_bank <= 1'b0;
      vid_wr_addr <= VA_W'(0);
      vid_wr_data <= '0;
      aud_wr_en   <= 1'b0;
      aud_wr_addr <= AA_W'(0);
      aud_wr_data <= '0;
      frame_done  <= 1'b0;
      err_partial <= 1'b0;
      err_short   <= 1'b0;
      err_both    <= 1'b0;
    end else begin
      vid_wr_en  <= 1'b0;
      aud_wr_en  <= 1'b0;
      frame_done <= 1'b0;

      if (data_clk_rising_edge && video_data_ready && audio_data_ready) begin
        err_both <= 1'b1;
      end

      if (vid_take_s) begin
        vid_sh_r <= vid_next_s[VID_WORD_W-2:0];
        if (vid_word_s) begin
          vid_wr_en   <= 1'b1;
          vid_wr_data <= vid_next_s;
          vid_wr_addr <= vid_idx_r;
          vid_cnt_r   <= VC_W'(0);
          if (vid_idx_r == VID_LAST) begin
            vid_idx_r  <= VA_W'(0);
            vid_full_r <= 1'b1;
          end else begin
            vid_idx_r <= vid_idx_r + VA_W'(1);
          end
        end else begin
          vid_cnt_r <= vid_cnt_r + VC_W'(1);
        end
      end else if (vid_drop_s) begin
        err_partial <= 1'b1;
        vid_cnt_r   <= VC_W'(0);
        vid_sh_r    <= '0;
      end

      if (aud_take_s) begin
        aud_sh_r <= aud_next_s[AUD_WORD_W-2:0];
        if (aud_word_s) begin
          aud_wr_en   <= 1'b1;
          aud_wr_data <= aud_next_s;
          aud_wr_addr <= aud_idx_r;
          aud_cnt_r   <= AC_W'(0);
          aud_idx_r   <= aud_idx_r + AA_W'(1);
        end else begin
          aud_cnt_r <= aud_cnt_r + AC_W'(1);
        end
      end else if (aud_drop_s) begin
        err_partial <= 1'b1;
        aud_cnt_r   <= AC_W'(0);
        aud_sh_r    <= '0;
      end

      case (state_r)
        IDLE: begin
          if (vid_strobe_s) begin
            state_r <= VIDEO;
          end else if (aud_strobe_s) begin
            state_r   <= AUDIO;
            err_short <= 1'b1;
          end else begin
            state_r <= IDLE;
          end
        end
        VIDEO: begin
          if (aud_strobe_s) begin
            state_r <= AUDIO;
            if (!vid_full_r) begin
              err_short <= 1'b1;
            end else begin
              err_short <= err_short;
            end
          end else begin
            state_r <= VIDEO;
          end
        end
        AUDIO: begin
          if (aud_word_s && (aud_idx_r == AUD_LAST)) begin
            state_r <= DONE;
          end else begin
            state_r <= AUDIO;
          end
        end
        DONE: begin
          // Only a frame with a full video image may be shown to the display
          state_r     <= IDLE;
          frame_done  <= 1'b1;
          vid_wr_bank <= vid_full_r ? ~vid_wr_bank : vid_wr_bank;
          vid_idx_r   <= VA_W'(0);
          aud_idx_r   <= AA_W'(0);
          vid_cnt_r   <= VC_W'(0);
          aud_cnt_r   <= AC_W'(0);
          vid_full_r  <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_deserializer.sv
// Scoreboard bench for frame_deserializer with a small frame geometry.
module tb_frame_deserializer;

  logic        CLK_40 = 1'b0;
  logic        reset;
  logic        data_clk_rising_edge;
  logic        received_bit;
  logic        video_data_ready;
  logic        audio_data_ready;
  logic        vid_wr_en;
  logic        vid_wr_bank;
  logic [1:0]  vid_wr_addr;
  logic [7:0]  vid_wr_data;
  logic        aud_wr_en;
  logic [0:0]  aud_wr_addr;
  logic [15:0] aud_wr_data;
  logic        frame_done;
  logic        err_partial;
  logic        err_short;
  logic        err_both;

  int n_checks = 0;
  int n_pass   = 0;
  int fd_seen  = 0;
  int exp_fd   = 0;
  int vq_addr[$];
  int vq_data[$];
  int aq_addr[$];
  int aq_data[$];

  frame_deserializer #(
    .VID_WORD_W(8), .VID_DEPTH(4), .AUD_WORD_W(16), .AUD_DEPTH(2)
  ) dut (
    .CLK_40(CLK_40), .reset(reset),
    .data_clk_rising_edge(data_clk_rising_edge), .received_bit(received_bit),
    .video_data_ready(video_data_ready), .audio_data_ready(audio_data_ready),
    .vid_wr_en(vid_wr_en), .vid_wr_bank(vid_wr_bank),
    .vid_wr_addr(vid_wr_addr), .vid_wr_data(vid_wr_data),
    .aud_wr_en(aud_wr_en), .aud_wr_addr(aud_wr_addr), .aud_wr_data(aud_wr_data),
    .frame_done(frame_done), .err_partial(err_partial),
    .err_short(err_short), .err_both(err_both)
  );

  always #5 CLK_40 = ~CLK_40;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every write strobe must match the oldest pending expectation
  always @(negedge CLK_40) begin
    if (vid_wr_en) begin
      chk("vid_write_expected", 32'(vq_data.size() != 0), 32'd1);
      if (vq_data.size() != 0) begin
        chk("vid_addr", 32'(vid_wr_addr), 32'(vq_addr.pop_front()));
        chk("vid_data", 32'(vid_wr_data), 32'(vq_data.pop_front()));
      end
    end
    if (aud_wr_en) begin
      chk("aud_write_expected", 32'(aq_data.size() != 0), 32'd1);
      if (aq_data.size() != 0) begin
        chk("aud_addr", 32'(aud_wr_addr), 32'(aq_addr.pop_front()));
        chk("aud_data", 32'(aud_wr_data), 32'(aq_data.pop_front()));
      end
    end
    if (frame_done) fd_seen++;
  end

  task automatic drive_bit(input logic b, input logic v, input logic a);
    data_clk_rising_edge = 1'b1;
    received_bit         = b;
    video_data_ready     = v;
    audio_data_ready     = a;
    @(posedge CLK_40); #1;
    data_clk_rising_edge = 1'b0;
    video_data_ready     = 1'b0;
    audio_data_ready     = 1'b0;
    @(posedge CLK_40); #1;
  endtask

  task automatic send_vbyte(input logic [7:0] w, input int addr);
    vq_addr.push_back(addr);
    vq_data.push_back(int'(w));
    for (int i = 7; i >= 0; i--) drive_bit(w[i], 1'b1, 1'b0);
  endtask

  task automatic send_aword(input logic [15:0] w, input int addr);
    aq_addr.push_back(addr);
    aq_data.push_back(int'(w));
    for (int i = 15; i >= 0; i--) drive_bit(w[i], 1'b0, 1'b1);
  endtask

  task automatic send_audio_tail();
    send_aword(16'h1234, 0);
    send_aword(16'hBEEF, 1);
    exp_fd++;
    repeat (4) @(posedge CLK_40);
    #1;
  endtask

  task automatic send_std_frame();
    send_vbyte(8'hA5, 0);
    send_vbyte(8'h3C, 1);
    send_vbyte(8'hFF, 2);
    send_vbyte(8'h01, 3);
    send_audio_tail();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(posedge CLK_40);
    #1;
    reset = 1'b1;
    @(posedge CLK_40); #1;
  endtask

  task automatic chk_errs(input string tag, input logic p, input logic s, input logic b);
    chk({tag, "_err_partial"}, 32'(err_partial), 32'(p));
    chk({tag, "_err_short"},   32'(err_short),   32'(s));
    chk({tag, "_err_both"},    32'(err_both),    32'(b));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_vid_wr_en"},   32'(vid_wr_en),   32'd0);
    chk({tag, "_vid_wr_bank"}, 32'(vid_wr_bank), 32'd0);
    chk({tag, "_vid_wr_addr"}, 32'(vid_wr_addr), 32'd0);
    chk({tag, "_vid_wr_data"}, 32'(vid_wr_data), 32'd0);
    chk({tag, "_aud_wr_en"},   32'(aud_wr_en),   32'd0);
    chk({tag, "_aud_wr_addr"}, 32'(aud_wr_addr), 32'd0);
    chk({tag, "_aud_wr_data"}, 32'(aud_wr_data), 32'd0);
    chk({tag, "_frame_done"},  32'(frame_done),  32'd0);
    chk_errs(tag, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b0;
    data_clk_rising_edge = 1'b0;
    received_bit = 1'b0;
    video_data_ready = 1'b0;
    audio_data_ready = 1'b0;
    #2;
    chk_all_zero("reset");
    repeat (2) @(posedge CLK_40);
    #1;
    reset = 1'b1;
    @(posedge CLK_40); #1;

    // Nominal frame, then the same frame back-to-back
    send_std_frame();
    chk("frame1_bank", 32'(vid_wr_bank), 32'd1);
    chk("frame1_done_cnt", 32'(fd_seen), 32'(exp_fd));
    chk_errs("frame1", 1'b0, 1'b0, 1'b0);
    send_std_frame();
    chk("frame2_bank", 32'(vid_wr_bank), 32'd0);
    chk("frame2_done_cnt", 32'(fd_seen), 32'(exp_fd));

    // Sparse strobes with received_bit toggling every cycle
    vq_addr.push_back(0);
    vq_data.push_back(32'hFF);
    for (int c = 0; c < 32; c++) begin
      received_bit         = (c % 2 == 0);
      data_clk_rising_edge = (c % 4 == 0);
      video_data_ready     = 1'b1;
      @(posedge CLK_40); #1;
      if (c == 24) chk("spacing_no_early_wr", 32'(vid_wr_en), 32'd0);
      if (c == 28) chk("spacing_wr_latency", 32'(vid_wr_en), 32'd1);
      if (c == 29) chk("spacing_wr_one_cycle", 32'(vid_wr_en), 32'd0);
    end
    data_clk_rising_edge = 1'b0;
    video_data_ready     = 1'b0;
    send_vbyte(8'h11, 1);
    send_vbyte(8'h22, 2);
    send_vbyte(8'h33, 3);
    send_audio_tail();
    chk("spacing_bank", 32'(vid_wr_bank), 32'd1);
    chk_errs("spacing", 1'b0, 1'b0, 1'b0);

    // Short frame: two video words only, bank must not swap
    send_vbyte(8'h6E, 0);
    send_vbyte(8'h91, 1);
    send_audio_tail();
    chk("short_bank_held", 32'(vid_wr_bank), 32'd1);
    chk("short_done_cnt", 32'(fd_seen), 32'(exp_fd));
    chk_errs("short", 1'b0, 1'b1, 1'b0);

    // Partial word abandoned by an unqualified strobe
    do_reset();
    for (int i = 0; i < 5; i++) drive_bit(i[0], 1'b1, 1'b0);
    drive_bit(1'b1, 1'b0, 1'b0);
    send_vbyte(8'h96, 0);
    chk_errs("partial", 1'b1, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a frame
    do_reset();
    send_vbyte(8'h5A, 0);
    send_vbyte(8'hC3, 1);
    for (int i = 0; i < 4; i++) drive_bit(1'b1, 1'b1, 1'b0);
    chk("pre_reset_addr", 32'(vid_wr_addr), 32'd1);
    reset = 1'b0;
    #1;
    chk_all_zero("async_reset");
    @(posedge CLK_40); #1;
    reset = 1'b1;
    @(posedge CLK_40); #1;
    send_std_frame();
    chk("post_reset_bank", 32'(vid_wr_bank), 32'd1);
    chk("post_reset_done_cnt", 32'(fd_seen), 32'(exp_fd));
    chk_errs("post_reset", 1'b0, 1'b0, 1'b0);

    // Both qualifiers in one strobe: video wins, err_both latches
    drive_bit(1'b1, 1'b1, 1'b1);
    chk_errs("both", 1'b0, 1'b0, 1'b1);

    repeat (3) @(posedge CLK_40);
    #1;
    chk("vid_queue_drained", 32'(vq_data.size()), 32'd0);
    chk("aud_queue_drained", 32'(aq_data.size()), 32'd0);
    chk("final_done_cnt", 32'(fd_seen), 32'(exp_fd));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
